// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver
// Double-buffers a 5x7 character frame and scans it onto an LED matrix one
// column at a time. Each column slot starts with a blanking gap. New frames
// move from the shadow buffer to the active buffer only at the frame boundary.
//
// Optional build macro: LED_SCAN_PWM_EN
//   Defined   : the DRIVE portion is split into 8 sub-windows and rows are lit
//               for the first brightness+1 of them (brightness sampled at frame_start).
//   Undefined : brightness is ignored; rows are lit for the whole DRIVE portion.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   frame_data   35-bit frame, bit c*5+r = column c, row r (1 = LED on)
//   frame_valid  frame_data valid
//   frame_ready  shadow buffer free (transfer on valid && ready)
//   brightness   PWM duty, used only with LED_SCAN_PWM_EN
//   col_n        one-hot active-low column select
//   row          active-high row drive for the selected column
//   frame_start  one-cycle pulse as column 0's slot begins
module led_matrix_scan_driver #(
    parameter  int unsigned COL_CYCLES   = 1000,
    parameter  int unsigned BLANK_CYCLES = 50,
    localparam int unsigned NUM_COLS     = 7,
    localparam int unsigned NUM_ROWS     = 5,
    localparam int unsigned FRAME_W      = NUM_COLS * NUM_ROWS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FRAME_W-1:0]  frame_data,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [2:0]          brightness,
    output logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row,
    output logic                frame_start
);

    localparam int unsigned CNT_W  = $clog2(COL_CYCLES);
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BASE_W = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(COL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_COLS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   active_q, active_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 swap_q;
    logic                 wrap, swap, accept;
    logic [BASE_W-1:0]    base;
    logic [NUM_COLS-1:0]  col_n_d;
    logic [NUM_ROWS-1:0]  row_d;

`ifdef LED_SCAN_PWM_EN
    localparam int unsigned SUB_CYCLES = (COL_CYCLES - BLANK_CYCLES) / 8;

    logic [2:0] bright_q;
    logic       pwm_on;

    // Lit while the offset into DRIVE lies inside the first brightness+1 sub-windows;
    // the remainder cycles after the 8th sub-window always fall outside.
    always_comb begin
        pwm_on = (32'(cnt_q) - BLANK_CYCLES) < ((32'(bright_q) + 32'd1) * SUB_CYCLES);
    end

    // Brightness is latched once per frame so a frame never changes duty mid-scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 3'd7;
        end else if (swap_q) begin
            bright_q <= brightness;
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
`endif

    // Next-state, slot counting, buffer control and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        col_n_d   = '1;
        row_d     = '0;
        wrap      = (cnt_q == CNT_LAST);
        swap      = wrap && (idx_q == IDX_LAST);
        accept    = frame_valid && !pending_q;
        base      = BASE_W'(idx_q) * BASE_W'(NUM_ROWS);

        if (wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            BLANK:   if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
            DRIVE:   if (wrap) state_d = BLANK;
            default: state_d = BLANK;
        endcase

        if (state_q == DRIVE) begin
            col_n_d = ~(NUM_COLS'(1) << idx_q);
            row_d   = active_q[base +: NUM_ROWS];
`ifdef LED_SCAN_PWM_EN
            if (!pwm_on) row_d = '0;
`endif
        end

        // Swap needs pending=1 and accept needs pending=0, so they are exclusive.
        if (swap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = frame_data;
            pending_d = 1'b1;
        end
    end

    // FSM and scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Frame buffers and handshake state; swap_q marks the first cycle of column 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            swap_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            swap_q    <= swap;
        end
    end

    // Registered outputs; frame_ready tracks !pending exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_n       <= '1;
            row         <= '0;
            frame_start <= 1'b0;
            frame_ready <= 1'b1;
        end else begin
            col_n       <= col_n_d;
            row         <= row_d;
            frame_start <= swap_q;
            frame_ready <= !pending_d;
        end
    end

endmodule
